ovi_sb_tracker: RTL and testbench

OVI_SB_TRACKER -- requirements
Module: ovi_sb_tracker

---
 rtl/ovi_sb_tracker.sv | 194 +++++++++++++++++++
 tb/tb_ovi_sb_tracker.sv | 558 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovi_sb_tracker.sv
// Scoreboard-id tracker between a scalar core and an OVI vector unit: id allocation, issue credits,
// senior/kill dispatch and completion forwarding. Define OVI_SB_TRACKER_CHK_EN to build the sticky protocol checker.
module ovi_sb_tracker #(
    parameter int unsigned INIT_CREDITS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_inst,
    input  logic [63:0] req_scalar,
    output logic        issue_valid,
    output logic [31:0] issue_inst,
    output logic [4:0]  issue_sb_id,
    output logic [63:0] issue_scalar_opnd,
    input  logic        issue_credit,
    input  logic        senior_valid,
    input  logic [4:0]  senior_sb_id,
    input  logic        kill_valid,
    input  logic [4:0]  kill_sb_id,
    output logic        dispatch_next_senior,
    output logic        dispatch_kill,
    output logic [4:0]  dispatch_sb_id,
    input  logic        completed_valid,
    input  logic [4:0]  completed_sb_id,
    output logic        cmpl_valid,
    output logic [4:0]  cmpl_sb_id,
    output logic        busy,
    output logic        proto_err
);

    localparam int unsigned NUM_IDS  = 32;
    localparam int unsigned ID_W     = 5;
    localparam int unsigned CRED_W   = 6;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned SCALAR_W = 64;

    typedef enum logic [1:0] {
        SB_FREE   = 2'd0,
        SB_ISSUED = 2'd1,
        SB_SENIOR = 2'd2
    } sb_state_e;

    sb_state_e           state_q [NUM_IDS];
    sb_state_e           state_d [NUM_IDS];
    logic [CRED_W-1:0]   credits_q;
    logic [CRED_W-1:0]   credits_d;

    logic [ID_W-1:0]     alloc_id;
    logic                accept;
    logic                senior_target_ok;
    logic                senior_ok;
    logic                kill_ok;
    logic                cmpl_ok;
    logic                credit_sat;

    logic                ready_d;
    logic                busy_d;
    logic                free_d;
    logic [ID_W-1:0]     disp_id_d;

    // Lowest-numbered FREE id, taken from registered state only.
    always_comb begin
        alloc_id = '0;
        for (int i = int'(NUM_IDS) - 1; i >= 0; i--) begin
            if (state_q[i] == SB_FREE) begin
                alloc_id = ID_W'(i);
            end
        end
    end

    assign accept = req_valid && req_ready;

    // Senior may target the id being allocated this very cycle, so dispatch can coincide with issue.
    assign senior_target_ok = (state_q[senior_sb_id] == SB_ISSUED) ||
                              (accept && (alloc_id == senior_sb_id));
    assign senior_ok  = senior_valid && !kill_valid && senior_target_ok;
    assign kill_ok    = kill_valid && (state_q[kill_sb_id] != SB_FREE);
    assign cmpl_ok    = completed_valid && (state_q[completed_sb_id] == SB_SENIOR);
    assign credit_sat = issue_credit && !accept && (credits_q == CRED_W'(INIT_CREDITS));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_IDS); i++) begin
                state_q[i] <= SB_FREE;
            end
            credits_q <= CRED_W'(INIT_CREDITS);
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
        end
    end

    // Next-state: id table and credit counter.
    always_comb begin
        state_d   = state_q;
        credits_d = credits_q;
        if (cmpl_ok) begin
            state_d[completed_sb_id] = SB_FREE;
        end
        if (kill_ok) begin
            state_d[kill_sb_id] = SB_FREE;
        end
        if (accept) begin
            state_d[alloc_id] = SB_ISSUED;
        end
        if (senior_ok) begin
            state_d[senior_sb_id] = SB_SENIOR;
        end
        if (accept && !issue_credit) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (issue_credit && !accept && !credit_sat) begin
            credits_d = credits_q + CRED_W'(1);
        end
    end

    // Output next-values; ready and busy look ahead at the next state so they register cleanly.
    always_comb begin
        free_d    = 1'b0;
        busy_d    = 1'b0;
        disp_id_d = dispatch_sb_id;
        for (int i = 0; i < int'(NUM_IDS); i++) begin
            if (state_d[i] == SB_FREE) begin
                free_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end
        ready_d = (credits_d != '0) && free_d;
        if (kill_ok) begin
            disp_id_d = kill_sb_id;
        end else if (senior_ok) begin
            disp_id_d = senior_sb_id;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_ready            <= 1'b0;
            busy                 <= 1'b0;
            issue_valid          <= 1'b0;
            issue_inst           <= '0;
            issue_sb_id          <= '0;
            issue_scalar_opnd    <= '0;
            dispatch_next_senior <= 1'b0;
            dispatch_kill        <= 1'b0;
            dispatch_sb_id       <= '0;
            cmpl_valid           <= 1'b0;
            cmpl_sb_id           <= '0;
        end else begin
            req_ready            <= ready_d;
            busy                 <= busy_d;
            issue_valid          <= accept;
            if (accept) begin
                issue_inst        <= INST_W'(req_inst);
                issue_sb_id       <= alloc_id;
                issue_scalar_opnd <= SCALAR_W'(req_scalar);
            end
            dispatch_next_senior <= senior_ok;
            dispatch_kill        <= kill_ok;
            dispatch_sb_id       <= disp_id_d;
            cmpl_valid           <= cmpl_ok;
            if (cmpl_ok) begin
                cmpl_sb_id <= completed_sb_id;
            end
        end
    end

`ifdef OVI_SB_TRACKER_CHK_EN
    logic illegal_event;
    logic proto_err_q;

    assign illegal_event = (senior_valid && (kill_valid || !senior_target_ok)) ||
                           (kill_valid && !kill_ok) ||
                           (completed_valid && !cmpl_ok) ||
                           credit_sat;

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            proto_err_q <= 1'b0;
        end else if (illegal_event) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_ovi_sb_tracker.sv
// Scoreboard bench for ovi_sb_tracker: expected issue/dispatch/completion pulses are queued at drive time
// and popped by a negedge monitor; directed tasks check ready/busy/proto_err inline.
`timescale 1ns/1ps
module tb_ovi_sb_tracker;
    localparam int unsigned INIT_CREDITS = 4;
`ifdef OVI_SB_TRACKER_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_inst;
    logic [63:0] req_scalar;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [4:0]  issue_sb_id;
    logic [63:0] issue_scalar_opnd;
    logic        issue_credit;
    logic        senior_valid;
    logic [4:0]  senior_sb_id;
    logic        kill_valid;
    logic [4:0]  kill_sb_id;
    logic        dispatch_next_senior;
    logic        dispatch_kill;
    logic [4:0]  dispatch_sb_id;
    logic        completed_valid;
    logic [4:0]  completed_sb_id;
    logic        cmpl_valid;
    logic [4:0]  cmpl_sb_id;
    logic        busy;
    logic        proto_err;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] inst;
        logic [63:0] scalar;
    } iss_t;
    typedef struct {
        logic       kill;
        logic [4:0] id;
    } disp_t;

    iss_t       iss_q[$];
    disp_t      disp_q[$];
    logic [4:0] cmpl_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    ovi_sb_tracker #(.INIT_CREDITS(INIT_CREDITS)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_inst             (req_inst),
        .req_scalar           (req_scalar),
        .issue_valid          (issue_valid),
        .issue_inst           (issue_inst),
        .issue_sb_id          (issue_sb_id),
        .issue_scalar_opnd    (issue_scalar_opnd),
        .issue_credit         (issue_credit),
        .senior_valid         (senior_valid),
        .senior_sb_id         (senior_sb_id),
        .kill_valid           (kill_valid),
        .kill_sb_id           (kill_sb_id),
        .dispatch_next_senior (dispatch_next_senior),
        .dispatch_kill        (dispatch_kill),
        .dispatch_sb_id       (dispatch_sb_id),
        .completed_valid      (completed_valid),
        .completed_sb_id      (completed_sb_id),
        .cmpl_valid           (cmpl_valid),
        .cmpl_sb_id           (cmpl_sb_id),
        .busy                 (busy),
        .proto_err            (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid       = 1'b0;
        req_inst        = '0;
        req_scalar      = '0;
        issue_credit    = 1'b0;
        senior_valid    = 1'b0;
        senior_sb_id    = '0;
        kill_valid      = 1'b0;
        kill_sb_id      = '0;
        completed_valid = 1'b0;
        completed_sb_id = '0;
    endtask

    task automatic push_issue(input logic [4:0] id, input logic [31:0] inst, input logic [63:0] sc);
        iss_t e;
        e.id     = id;
        e.inst   = inst;
        e.scalar = sc;
        iss_q.push_back(e);
    endtask

    task automatic push_disp(input logic kill, input logic [4:0] id);
        disp_t e;
        e.kill = kill;
        e.id   = id;
        disp_q.push_back(e);
    endtask

    task automatic drive_req(input logic [4:0] exp_id);
        req_inst   = $urandom();
        req_scalar = {$urandom(), $urandom()};
        req_valid  = 1'b1;
        push_issue(exp_id, req_inst, req_scalar);
    endtask

    // Pops the scoreboard whenever the DUT produces a pulse.
    task automatic monitor();
        iss_t       ie;
        disp_t      de;
        logic [4:0] ce;
        forever begin
            @(negedge clk);
            if (issue_valid === 1'b1) begin
                n_cmp++;
                if (iss_q.size() == 0) begin
                    n_err++;
                    $display("FAIL issue_unexpected: got issue id %0d, required no issue", issue_sb_id);
                end else begin
                    ie = iss_q.pop_front();
                    if (issue_sb_id !== ie.id || issue_inst !== ie.inst || issue_scalar_opnd !== ie.scalar) begin
                        n_err++;
                        $display("FAIL issue_payload: got id %0d inst %h scalar %h, required id %0d inst %h scalar %h",
                                 issue_sb_id, issue_inst, issue_scalar_opnd, ie.id, ie.inst, ie.scalar);
                    end
                end
            end
            if (dispatch_next_senior === 1'b1 || dispatch_kill === 1'b1) begin
                n_cmp++;
                if (disp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL dispatch_unexpected: got senior %b kill %b id %0d, required no dispatch",
                             dispatch_next_senior, dispatch_kill, dispatch_sb_id);
                end else begin
                    de = disp_q.pop_front();
                    if (dispatch_kill !== de.kill || dispatch_next_senior !== !de.kill || dispatch_sb_id !== de.id) begin
                        n_err++;
                        $display("FAIL dispatch_payload: got senior %b kill %b id %0d, required senior %b kill %b id %0d",
                                 dispatch_next_senior, dispatch_kill, dispatch_sb_id, !de.kill, de.kill, de.id);
                    end
                end
            end
            if (cmpl_valid === 1'b1) begin
                n_cmp++;
                if (cmpl_q.size() == 0) begin
                    n_err++;
                    $display("FAIL cmpl_unexpected: got cmpl id %0d, required no completion", cmpl_sb_id);
                end else begin
                    ce = cmpl_q.pop_front();
                    if (cmpl_sb_id !== ce) begin
                        n_err++;
                        $display("FAIL cmpl_id: got %0d, required %0d", cmpl_sb_id, ce);
                    end
                end
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1;
        n_cmp++;
        if (iss_q.size() != 0 || disp_q.size() != 0 || cmpl_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d/%0d issue/dispatch/cmpl pulses missing, required 0/0/0",
                     iss_q.size(), disp_q.size(), cmpl_q.size());
        end
        iss_q.delete();
        disp_q.delete();
        cmpl_q.delete();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({req_ready, issue_valid, dispatch_next_senior, dispatch_kill, cmpl_valid, busy, proto_err} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got ready/iss/sen/kill/cmpl/busy/err %b%b%b%b%b%b%b, required 0000000",
                     req_ready, issue_valid, dispatch_next_senior, dispatch_kill, cmpl_valid, busy, proto_err);
        end
        n_cmp++;
        if (issue_sb_id !== 5'd0 || dispatch_sb_id !== 5'd0 || cmpl_sb_id !== 5'd0 ||
            issue_inst !== 32'd0 || issue_scalar_opnd !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data: got ids %0d/%0d/%0d inst %h scalar %h, required all zero",
                     issue_sb_id, dispatch_sb_id, cmpl_sb_id, issue_inst, issue_scalar_opnd);
        end
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b, required 1", req_ready);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_reset: got %b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready_%0d: got %b, required 1", k, req_ready);
            end
            drive_req(5'(k));
            tick();
        end
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_no_credit: got ready %b, required 0", req_ready);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_busy: got %b, required 1", busy);
        end
        tick();
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_still_no_credit: got ready %b, required 0", req_ready);
        end
        issue_credit = 1'b1;
        tick();
        issue_credit = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_credit_return: got ready %b, required 1", req_ready);
        end
        tick();
    endtask

    task automatic test_senior_complete();
        reset_dut();
        drive_req(5'd0);
        tick();
        req_valid    = 1'b0;
        senior_valid = 1'b1;
        senior_sb_id = 5'd0;
        push_disp(1'b0, 5'd0);
        tick();
        senior_valid    = 1'b0;
        completed_valid = 1'b1;
        completed_sb_id = 5'd0;
        cmpl_q.push_back(5'd0);
        tick();
        completed_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL cmpl_busy_fall: got busy %b, required 0", busy);
        end
        // Senior in the accept cycle: dispatch lands together with the issue pulse.
        drive_req(5'd0);
        senior_valid = 1'b1;
        senior_sb_id = 5'd0;
        push_disp(1'b0, 5'd0);
        tick();
        req_valid    = 1'b0;
        senior_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL reuse_busy: got busy %b, required 1", busy);
        end
        completed_valid = 1'b1;
        completed_sb_id = 5'd0;
        cmpl_q.push_back(5'd0);
        tick();
        completed_valid = 1'b0;
        tick();
    endtask

    task automatic test_kill();
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            drive_req(5'(k));
            tick();
        end
        req_valid  = 1'b0;
        kill_valid = 1'b1;
        kill_sb_id = 5'd1;
        push_disp(1'b1, 5'd1);
        tick();
        kill_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL kill_ready: got %b, required 1", req_ready);
        end
        drive_req(5'd1);
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL kill_credits_out: got ready %b, required 0", req_ready);
        end
        tick();
    endtask

    task automatic test_senior_kill();
        reset_dut();
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL sk_err_clear: got %b, required 0", proto_err);
        end
        for (int k = 0; k < 3; k++) begin
            drive_req(5'(k));
            tick();
        end
        req_valid    = 1'b0;
        senior_valid = 1'b1;
        senior_sb_id = 5'd2;
        kill_valid   = 1'b1;
        kill_sb_id   = 5'd2;
        push_disp(1'b1, 5'd2);
        tick();
        senior_valid = 1'b0;
        kill_valid   = 1'b0;
        n_cmp++;
        if (proto_err !== EXP_ERR) begin
            n_err++;
            $display("FAIL sk_proto_err: got %b, required %b", proto_err, EXP_ERR);
        end
        // id 2 is FREE again, so a late senior on it must not dispatch.
        senior_valid = 1'b1;
        senior_sb_id = 5'd2;
        tick();
        senior_valid = 1'b0;
        drive_req(5'd2);
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        reset_dut();
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL ill_err_clear: got %b, required 0", proto_err);
        end
        issue_credit = 1'b1;
        tick();
        issue_credit = 1'b0;
        n_cmp++;
        if (proto_err !== EXP_ERR) begin
            n_err++;
            $display("FAIL ill_overflow_err: got %b, required %b", proto_err, EXP_ERR);
        end
        for (int k = 0; k < 4; k++) begin
            drive_req(5'(k));
            tick();
        end
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ill_credit_sat: got ready %b, required 0", req_ready);
        end
        completed_valid = 1'b1;
        completed_sb_id = 5'd0;
        tick();
        completed_valid = 1'b0;
        kill_valid      = 1'b1;
        kill_sb_id      = 5'd9;
        tick();
        kill_valid   = 1'b0;
        senior_valid = 1'b1;
        senior_sb_id = 5'd0;
        push_disp(1'b0, 5'd0);
        tick();
        senior_valid = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL ill_busy: got %b, required 1", busy);
        end
    endtask

    task automatic test_fill();
        reset_dut();
        issue_credit = 1'b1;
        for (int k = 0; k < 32; k++) begin
            n_cmp++;
            if (req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL fill_ready_%0d: got %b, required 1", k, req_ready);
            end
            drive_req(5'(k));
            tick();
        end
        req_valid    = 1'b0;
        issue_credit = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: got ready %b, required 0", req_ready);
        end
        senior_valid = 1'b1;
        senior_sb_id = 5'd17;
        push_disp(1'b0, 5'd17);
        tick();
        senior_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_ready_at_cmpl: got %b, required 0", req_ready);
        end
        // Request held across the completion edge must not grab id 17 in that same edge.
        completed_valid = 1'b1;
        completed_sb_id = 5'd17;
        cmpl_q.push_back(5'd17);
        req_inst   = $urandom();
        req_scalar = {$urandom(), $urandom()};
        req_valid  = 1'b1;
        tick();
        completed_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL fill_ready_after_free: got %b, required 1", req_ready);
        end
        push_issue(5'd17, req_inst, req_scalar);
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_refull: got ready %b, required 0", req_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            drive_req(5'(k));
            tick();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            senior_valid = 1'b1;
            senior_sb_id = 5'(k);
            push_disp(1'b0, 5'(k));
            tick();
        end
        senior_valid = 1'b0;
        drive_req(5'd3);
        tick();
        // Reset with traffic still pending; nothing further may emerge.
        req_inst     = $urandom();
        senior_valid = 1'b1;
        senior_sb_id = 5'd3;
        issue_credit = 1'b1;
        reset_n      = 1'b0;
        tick();
        idle_inputs();
        n_cmp++;
        if ({req_ready, issue_valid, dispatch_next_senior, dispatch_kill, cmpl_valid, busy, proto_err} !== 7'b0) begin
            n_err++;
            $display("FAIL mid_reset_ctrl: got ready/iss/sen/kill/cmpl/busy/err %b%b%b%b%b%b%b, required 0000000",
                     req_ready, issue_valid, dispatch_next_senior, dispatch_kill, cmpl_valid, busy, proto_err);
        end
        n_cmp++;
        if (issue_sb_id !== 5'd0 || dispatch_sb_id !== 5'd0 || issue_inst !== 32'd0 || issue_scalar_opnd !== 64'd0) begin
            n_err++;
            $display("FAIL mid_reset_data: got iss id %0d disp id %0d inst %h scalar %h, required all zero",
                     issue_sb_id, dispatch_sb_id, issue_inst, issue_scalar_opnd);
        end
        tick();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL mid_ready_%0d: got %b, required 1", k, req_ready);
            end
            drive_req(5'(k));
            tick();
        end
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_credits_restored: got ready %b, required 0", req_ready);
        end
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        fork
            monitor();
        join_none
        test_reset();
        test_back_to_back();
        test_senior_complete();
        test_kill();
        test_senior_kill();
        test_illegal();
        test_fill();
        test_reset_mid();
        tick();
        @(negedge clk);
        #1;
        n_cmp++;
        if (iss_q.size() != 0 || disp_q.size() != 0 || cmpl_q.size() != 0) begin
            n_err++;
            $display("FAIL final_drain: got %0d/%0d/%0d pulses missing, required 0/0/0",
                     iss_q.size(), disp_q.size(), cmpl_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
